// File: rtl/nn_stream_pkg.sv
// Shared state encoding and default sizing for the sample streamer.
// The top is built with or without the NN_STREAM_CHECKSUM_EN macro; both builds share this package.
package nn_stream_pkg;

   localparam int NN_DATA_W = 8;
   localparam int NN_DEPTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_CSUM = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/nn_stream_buf.sv
// Sample buffer: DEPTH x DATA_W register array, one write port, combinational read.
module nn_stream_buf
   import nn_stream_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int DEPTH  = NN_DEPTH
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [DATA_W-1:0]          rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr] = wr_data;
      end
   end

   // Contents need no reset: the top's count decides which entries are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/nn_sample_streamer.sv
// Buffers host samples and streams them as one valid/ready frame with out_last and a done pulse.
// Define NN_STREAM_CHECKSUM_EN to append a mod-2^DATA_W checksum beat to every frame.
module nn_sample_streamer
   import nn_stream_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int DEPTH  = NN_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   input  logic                         start,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_last,
   output logic                         done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               done_q, done_d;
   logic               wr_ready_q, wr_ready_d;
   logic               busy_q, busy_d;
`ifdef NN_STREAM_CHECKSUM_EN
   logic [DATA_W-1:0]  csum_q, csum_d;
`endif

   logic               buf_we;
   logic [PTR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]  rd_data;

   nn_stream_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_ptr  (wr_ptr_q),
      .wr_data (wr_data),
      .rd_ptr  (rd_addr),
      .rd_data (rd_data)
   );

   // Outputs are registered, so each transition preloads the beat that will be shown next.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      buf_we      = 1'b0;
      rd_addr     = rd_ptr_q;
`ifdef NN_STREAM_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            buf_we = wr_en && wr_ready_q;
            if (buf_we) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end
            if (start && (count_d != '0)) begin
               state_d     = ST_SEND;
               remaining_d = count_d;
               out_valid_d = 1'b1;
               // An empty buffer means the first sample is the one being written right now.
               out_data_d  = (count_q == '0) ? wr_data : rd_data;
`ifdef NN_STREAM_CHECKSUM_EN
               out_last_d  = 1'b0;
               csum_d      = '0;
`else
               out_last_d  = (count_d == CNT_W'(1));
`endif
            end
         end

         ST_SEND: begin
            rd_addr = rd_ptr_q + 1'b1;
            if (out_ready) begin
               rd_ptr_d    = rd_ptr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
`ifdef NN_STREAM_CHECKSUM_EN
               csum_d      = csum_q + out_data_q;
`endif
               if (remaining_q == CNT_W'(1)) begin
`ifdef NN_STREAM_CHECKSUM_EN
                  state_d     = ST_CSUM;
                  out_data_d  = csum_q + out_data_q;
                  out_last_d  = 1'b1;
`else
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  count_d     = '0;
`endif
               end else begin
                  out_data_d = rd_data;
`ifdef NN_STREAM_CHECKSUM_EN
                  out_last_d = 1'b0;
`else
                  out_last_d = (remaining_q == CNT_W'(2));
`endif
               end
            end
         end

`ifdef NN_STREAM_CHECKSUM_EN
         ST_CSUM: begin
            if (out_ready) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
               count_d     = '0;
            end
         end
`endif

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d     = (state_d != ST_IDLE);
      wr_ready_d = (state_d == ST_IDLE) && (count_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         wr_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
`ifdef NN_STREAM_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         wr_ready_q  <= wr_ready_d;
         busy_q      <= busy_d;
`ifdef NN_STREAM_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign wr_ready  = wr_ready_q;
   assign busy      = busy_q;
   assign count     = count_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

endmodule
